// File: rtl/pipe_rc_adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
// Default geometry and the stage-count / split-legality functions.
package pipe_rc_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  function automatic int nstage(input int w, input int s);
    return (s > 0) ? w / s : 0;
  endfunction

  function automatic bit split_ok(input int w, input int s);
    return (s > 0) && (w >= s) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/rc_seg_adder.sv
// Combinational SEG-bit ripple-carry segment.
// c_msb is the carry into the top bit, used for signed overflow.
module rc_seg_adder
  import pipe_rc_adder_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipe_rc_adder.sv
// Pipelined ripple-carry adder/subtractor, one SEG-bit segment per stage.
// All stages advance together; a stall freezes the whole pipe.
module pipe_rc_adder
  import pipe_rc_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSTAGE = nstage(WIDTH, SEG);

  if (!split_ok(WIDTH, SEG)) begin : g_bad_split
    $error("pipe_rc_adder: WIDTH must be a multiple of SEG");
  end

  logic [NSTAGE-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [NSTAGE-1:0][WIDTH-1:0] a_src, b_src, s_src;
  logic [NSTAGE-1:0][WIDTH-1:0] s_nxt;
  logic [NSTAGE-1:0][SEG-1:0]   seg_s;
  logic [NSTAGE-1:0]            v_q, c_q;
  logic [NSTAGE-1:0]            v_src, c_src;
  logic [NSTAGE-1:0]            co, cm;
  logic                         ov_q;
  logic                         adv;

  assign adv      = out_ready | ~v_q[NSTAGE-1];
  assign in_ready = adv;

  // Operands shift down by SEG per stage, so every
  // stage consumes the low segment of what it holds.
  always_comb begin
    a_src = '0;
    b_src = '0;
    s_src = '0;
    c_src = '0;
    v_src = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (k == 0) begin
        a_src[0] = a;
        b_src[0] = b ^ {WIDTH{sub}};
        s_src[0] = '0;
        c_src[0] = sub | cin;
        v_src[0] = in_valid;
      end else begin
        a_src[k] = a_q[k-1];
        b_src[k] = b_q[k-1];
        s_src[k] = s_q[k-1];
        c_src[k] = c_q[k-1];
        v_src[k] = v_q[k-1];
      end
    end
    s_nxt = s_src;
    for (int k = 0; k < NSTAGE; k++) begin
      s_nxt[k][k*SEG +: SEG] = seg_s[k];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    rc_seg_adder #(.SEG(SEG)) u_seg (
      .a     (a_src[k][SEG-1:0]),
      .b     (b_src[k][SEG-1:0]),
      .cin   (c_src[k]),
      .sum   (seg_s[k]),
      .cout  (co[k]),
      .c_msb (cm[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      c_q  <= '0;
      ov_q <= 1'b0;
    end else if (adv) begin
      v_q  <= v_src;
      c_q  <= co;
      s_q  <= s_nxt;
      ov_q <= co[NSTAGE-1] ^ cm[NSTAGE-1];
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k] <= a_src[k] >> SEG;
        b_q[k] <= b_src[k] >> SEG;
      end
    end
  end

  assign out_valid = v_q[NSTAGE-1];
  assign sum       = s_q[NSTAGE-1];
  assign carry_out = c_q[NSTAGE-1];
  assign overflow  = ov_q;

endmodule

// File: doc/pipe_rc_adder.md
# pipe_rc_adder

- Parametrised, pipelined ripple-carry adder/subtractor for the matrix-multiplier datapath.
- Splits a WIDTH-bit add into SEG-bit ripple segments, one segment per pipeline stage, with carry registered between stages.
- Accepts one operand pair per cycle under a valid/ready handshake and returns sum, carry-out and signed overflow after a fixed latency.
- Sits between the partial-product array and the accumulator, replacing fixed 4-bit ripple adders where wider words and higher clock rates are needed.

## Interface

Parameters:
- WIDTH, 16 — operand and sum width; must be a multiple of SEG.
- SEG, 4 — bits added per pipeline stage; NSTAGE = WIDTH/SEG (≥1).

Ports:
- clk  in  1  — rising-edge clock; the only clock.
- rst  in  1  — synchronous, active-high reset.
- in_valid  in  1  — operand pair on a, b, sub, cin is valid.
- in_ready  out  1  — block can accept this cycle.
- a  in  WIDTH  — operand A.
- b  in  WIDTH  — operand B.
- sub  in  1  — 0: A+B+cin; 1: A+~B+1 (cin ignored).
- cin  in  1  — carry-in when sub=0.
- out_valid  out  1  — result valid.
- out_ready  in  1  — downstream accepts the result.
- sum  out  WIDTH  — result, modulo 2^WIDTH.
- carry_out  out  1  — carry out of bit WIDTH-1; when sub=1, 1 means no borrow.
- overflow  out  1  — signed overflow: carry into MSB XOR carry out of MSB.

## Operation

- Stage k (0..NSTAGE-1) adds bits [k·SEG +: SEG] of A and B' (B' = sub ? ~B : B) with the carry from stage k-1. Stage 0 takes carry = sub ? 1 : cin.
- Each stage register holds:
  - the finished low sum bits;
  - the not-yet-added upper A/B' bits;
  - the carry;
  - a valid bit.
- The last stage also captures carry into the MSB for overflow.
- Global advance: adv = out_ready | ~out_valid. All stages shift together when adv=1 and hold when adv=0. Bubbles are not collapsed.
- in_ready = adv, combinational from out_ready and the last-stage valid.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- The stage-0 valid bit loads in_valid when adv=1, so a bubble enters when in_valid=0.
- sum, carry_out and overflow are driven directly from last-stage registers and are stable while out_valid=1 and out_ready=0.
- Arithmetic is unsigned modulo 2^WIDTH. Signed interpretation comes only through overflow.
- Inputs must not change the result of an accepted transaction. Operands are sampled only at input transfer.

## Timing

- Latency is NSTAGE cycles from input transfer to out_valid, when no stall occurs.
- Throughput is 1 result per cycle while out_ready=1.
- Reset behaviour (rst=1 at a rising edge):
  - all valid bits, sum, carry_out and overflow clear to 0;
  - out_valid=0, so in_ready=1 during and after reset;
  - in-flight data is discarded with no partial output;
  - inputs are ignored in the reset cycle.
- Simultaneous input and output transfer in the same cycle is supported: full rate, no bubble.
- Stall: out_ready=0 with out_valid=1 freezes every stage, including empty ones, and deasserts in_ready that cycle.
- NSTAGE=1 degenerates to a single registered SEG=WIDTH ripple adder with the same handshake.
- Critical path: one SEG-bit ripple plus the adv fan-out.

## Structure

- A shared package pipe_rc_adder_pkg holds:
  - the default-parameter constants;
  - a helper function computing NSTAGE;
  - an elaboration check that WIDTH % SEG == 0.
- One sub-module: rc_seg_adder (parameter SEG), a combinational SEG-bit ripple adder with inputs a, b, cin and outputs sum, cout, c_msb (the carry into its top bit).
  - It is instantiated once per stage inside a generate loop.
  - Stage registers live in the top module.

## Test plan

Defaults throughout: WIDTH=16, SEG=4, latency 4.

- Basic add: a=0x1234, b=0x0FFF, sub=0, cin=0, out_ready=1 → after 4 cycles sum=0x2233, carry_out=0, overflow=0.
- Carry chain across all segments, then subtract:
  - a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, carry_out=1, overflow=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, carry_out=1, overflow=1.
- Back-to-back stream: 8 consecutive pairs a=i, b=0x00F0·i → 8 results in order on consecutive cycles starting 4 cycles after the first input; in_ready stays 1.
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1.
  - sum stays constant and in_ready=0 throughout.
  - On release, the remaining results drain in order with no loss or duplication.
- Reset mid-flight: assert rst for 1 cycle with 3 transactions in flight → out_valid=0 next cycle, none of the 3 results ever appear, and a new input is accepted immediately after reset.
- Randomized check at NSTAGE=1 (SEG=16) and at WIDTH=32/SEG=8: compare every output against a golden A±B model, with out_ready toggled randomly.
